// File: rtl/flex_pts_tx.sv
// Parallel-to-serial word transmitter: valid/ready load, CLKS_PER_BIT pacing per bit,
// selectable bit order, and one-cycle word_start / word_done framing strobes.
module flex_pts_tx #(
  parameter int   NUM_BITS     = 32,
  parameter int   SHIFT_MSB    = 1,
  parameter int   CLKS_PER_BIT = 1,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                load_valid,
  input  logic [NUM_BITS-1:0] load_data,
  output logic                load_ready,
  output logic                serial_out,
  output logic                serial_valid,
  output logic                word_start,
  output logic                word_done,
  output logic                busy
);

  localparam int BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int PER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_BITS - 1);
  localparam logic [PER_W-1:0] LAST_PER = PER_W'(CLKS_PER_BIT - 1);

  // busy is the registered image of the state, so it doubles as the FSM debug view.
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              state, state_d;
  logic [NUM_BITS-1:0] shreg, shreg_d;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_d;
  logic [PER_W-1:0]    per_cnt, per_cnt_d;
  logic                serial_out_d, serial_valid_d, word_start_d, word_done_d;
  logic                last_cycle, transfer;

  function automatic logic out_bit(input logic [NUM_BITS-1:0] w);
    return (SHIFT_MSB != 0) ? w[NUM_BITS-1] : w[0];
  endfunction

  function automatic logic [NUM_BITS-1:0] advance(input logic [NUM_BITS-1:0] w);
    return (SHIFT_MSB != 0) ? {w[NUM_BITS-2:0], 1'b0} : {1'b0, w[NUM_BITS-1:1]};
  endfunction

  // Handshake: a word moves on any rising edge where load_valid && load_ready.
  // load_ready opens in IDLE and in the final cycle of the last bit (zero-gap
  // back-to-back words); clear closes it unconditionally.
  assign last_cycle = (state == SEND) && (bit_cnt == LAST_BIT) && (per_cnt == LAST_PER);
  assign load_ready = !clear && ((state == IDLE) || last_cycle);
  assign transfer   = load_valid && load_ready;

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    per_cnt_d = per_cnt;
    if (clear) begin
      state_d   = IDLE;
      shreg_d   = '0;
      bit_cnt_d = '0;
      per_cnt_d = '0;
    end else if (transfer) begin
      state_d   = SEND;
      shreg_d   = load_data;
      bit_cnt_d = '0;
      per_cnt_d = '0;
    end else if (state == SEND) begin
      if (per_cnt == LAST_PER) begin
        per_cnt_d = '0;
        if (bit_cnt == LAST_BIT) begin
          state_d = IDLE;
        end else begin
          bit_cnt_d = bit_cnt + 1'b1;
          shreg_d   = advance(shreg);
        end
      end else begin
        per_cnt_d = per_cnt + 1'b1;
      end
    end

    // Outputs are registered, so they are derived from the next-state values.
    serial_valid_d = (state_d == SEND);
    serial_out_d   = serial_valid_d ? out_bit(shreg_d) : IDLE_LEVEL;
    word_start_d   = (state_d == SEND) && transfer;
    word_done_d    = (state_d == SEND) && (bit_cnt_d == LAST_BIT) && (per_cnt_d == LAST_PER);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      per_cnt      <= '0;
      serial_out   <= IDLE_LEVEL;
      serial_valid <= 1'b0;
      word_start   <= 1'b0;
      word_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      shreg        <= shreg_d;
      bit_cnt      <= bit_cnt_d;
      per_cnt      <= per_cnt_d;
      serial_out   <= serial_out_d;
      serial_valid <= serial_valid_d;
      word_start   <= word_start_d;
      word_done    <= word_done_d;
      busy         <= (state_d == SEND);
    end
  end

endmodule
